// File: rtl/addsub_accum_pkg.sv
// Shared types and default sizing for the registered add/subtract/accumulate unit.
package addsub_accum_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_SAT = 2'b11
    } mode_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ACC_W = 16;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/addsub_accum_sat_adder.sv
// Three-input adder with carry-out and optional clamp to all-ones on carry.
module sat_adder #(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] base,
    input  logic [ACC_W-1:0] x,
    input  logic [ACC_W-1:0] y,
    input  logic             sat_en,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W:0] full_s;

    // One extra bit is enough: operands are narrower than the accumulator.
    always_comb begin
        full_s = {1'b0, base} + {1'b0, x} + {1'b0, y};
        ovf    = full_s[ACC_W];
        if (sat_en && full_s[ACC_W]) begin
            sum = {ACC_W{1'b1}};
        end else begin
            sum = full_s[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/addsub_accum.sv
// Registered add/sub/accumulate unit with valid/ready handshake on both sides,
// a carry/borrow flag and a wrapping count of accepted beats.
module addsub_accum
    import addsub_accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow,
    output logic [CNT_W-1:0] count
);

    if (ACC_W < WIDTH + 1) begin : g_bad_acc_w
        $error("addsub_accum: ACC_W must be at least WIDTH+1");
    end

    logic             out_valid_r;
    logic [ACC_W-1:0] result_r;
    logic             overflow_r;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] count_r;

    logic             accept_s;
    mode_t            mode_s;
    logic [ACC_W-1:0] a_ext_s;
    logic [ACC_W-1:0] b_ext_s;
    logic [ACC_W-1:0] base_s;
    logic [ACC_W-1:0] sum_s;
    logic             carry_s;
    logic             sat_en_s;
    logic [ACC_W-1:0] result_nxt_s;
    logic             overflow_nxt_s;
    logic [ACC_W-1:0] acc_nxt_s;

    assign in_ready = !rst && (!out_valid_r || out_ready);
    assign accept_s = in_valid && in_ready;
    assign mode_s   = mode_t'(mode);
    assign a_ext_s  = {{(ACC_W-WIDTH){1'b0}}, a};
    assign b_ext_s  = {{(ACC_W-WIDTH){1'b0}}, b};
    assign base_s   = clear ? {ACC_W{1'b0}} : acc_r;
    assign sat_en_s = (mode_s == MODE_SAT);

    sat_adder #(.ACC_W(ACC_W)) u_sat_adder (
        .base   (base_s),
        .x      (a_ext_s),
        .y      (b_ext_s),
        .sat_en (sat_en_s),
        .sum    (sum_s),
        .ovf    (carry_s)
    );

    // Mode mux: next result, flag and accumulator for an accepted beat.
    always_comb begin
        result_nxt_s   = {ACC_W{1'b0}};
        overflow_nxt_s = 1'b0;
        acc_nxt_s      = base_s;
        case (mode_s)
            MODE_ADD: begin
                result_nxt_s = a_ext_s + b_ext_s;
            end
            MODE_SUB: begin
                result_nxt_s   = a_ext_s - b_ext_s;
                overflow_nxt_s = (a < b);
            end
            MODE_ACC, MODE_SAT: begin
                result_nxt_s   = sum_s;
                overflow_nxt_s = carry_s;
                acc_nxt_s      = sum_s;
            end
            default: begin
                result_nxt_s   = {ACC_W{1'b0}};
                overflow_nxt_s = 1'b0;
                acc_nxt_s      = acc_r;
            end
        endcase
    end

    // Output register: load on accept, drop valid once consumed, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= {ACC_W{1'b0}};
            overflow_r  <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            result_r    <= result_nxt_s;
            overflow_r  <= overflow_nxt_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Accumulator and beat counter advance only on accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r   <= {ACC_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            acc_r   <= acc_nxt_s;
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign overflow  = overflow_r;
    assign count     = count_r;

endmodule

// File: tb/tb_addsub_accum.sv
// Directed test of addsub_accum: a 16-bit and a 10-bit accumulator instance
// share stimulus; expected values are hand-computed constants.
module tb_addsub_accum;
    import addsub_accum_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  mode;
    logic        clear;
    logic        out_ready;

    logic        in_ready16, out_valid16, overflow16;
    logic [15:0] result16;
    logic [7:0]  count16;
    logic        in_ready10, out_valid10, overflow10;
    logic [9:0]  result10;
    logic [7:0]  count10;

    int n_vec = 0;
    int n_err = 0;

    addsub_accum #(.WIDTH(8), .ACC_W(16), .CNT_W(8)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a), .b(b), .mode(mode), .clear(clear),
        .out_valid(out_valid16), .out_ready(out_ready),
        .result(result16), .overflow(overflow16), .count(count16)
    );

    addsub_accum #(.WIDTH(8), .ACC_W(10), .CNT_W(8)) u10 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready10),
        .a(a), .b(b), .mode(mode), .clear(clear),
        .out_valid(out_valid10), .out_ready(out_ready),
        .result(result10), .overflow(overflow10), .count(count10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one beat, let it be accepted at the next edge, sample 1 time unit later.
    task automatic beat(input logic [1:0] m, input logic [7:0] aa, input logic [7:0] bb,
                        input logic clr);
        in_valid = 1'b1;
        mode     = m;
        a        = aa;
        b        = bb;
        clear    = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = 8'd0; b = 8'd0;
        mode = MODE_ADD; clear = 1'b0; out_ready = 1'b1;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check_eq("in_ready_in_reset", in_ready16, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", in_ready16, 1'b1);
        check_eq("rst_out_valid", out_valid16, 1'b0);
        check_eq("rst_result", result16, 16'd0);
        check_eq("rst_overflow", overflow16, 1'b0);
        check_eq("rst_count", count16, 8'd0);

        // ADD and SUB
        beat(MODE_ADD, 8'd200, 8'd100, 1'b0);
        check_eq("add_valid", out_valid16, 1'b1);
        check_eq("add_result", result16, 16'd300);
        check_eq("add_ovf", overflow16, 1'b0);
        check_eq("add_count", count16, 8'd1);
        beat(MODE_SUB, 8'd5, 8'd7, 1'b0);
        check_eq("sub_result16", result16, 16'hFFFE);
        check_eq("sub_ovf16", overflow16, 1'b1);
        check_eq("sub_result10", result10, 10'h3FE);
        beat(MODE_SUB, 8'd9, 8'd7, 1'b0);
        check_eq("sub_nb_result", result16, 16'd2);
        check_eq("sub_nb_ovf", overflow16, 1'b0);
        idle();
        check_eq("drain_valid", out_valid16, 1'b0);
        check_eq("drain_result", result16, 16'd2);

        // Backpressure
        out_ready = 1'b0;
        beat(MODE_ADD, 8'd1, 8'd1, 1'b0);
        check_eq("bp_result", result16, 16'd2);
        check_eq("bp_in_ready", in_ready16, 1'b0);
        in_valid = 1'b1; mode = MODE_ADD; a = 8'd9; b = 8'd9;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold_valid", out_valid16, 1'b1);
            check_eq("bp_hold_result", result16, 16'd2);
            check_eq("bp_hold_count", count16, 8'd4);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", in_ready16, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("bp_new_result", result16, 16'd18);
        check_eq("bp_new_count", count16, 8'd5);

        // Wrap-around accumulate on the 10-bit instance
        beat(MODE_ACC, 8'd0, 8'd0, 1'b1);
        check_eq("acc_clr0", result10, 10'd0);
        beat(MODE_ACC, 8'd255, 8'd255, 1'b0);
        check_eq("acc_1", result10, 10'd510);
        beat(MODE_ACC, 8'd255, 8'd255, 1'b0);
        check_eq("acc_2", result10, 10'd1020);
        check_eq("acc_2_ovf", overflow10, 1'b0);
        beat(MODE_ACC, 8'd255, 8'd255, 1'b0);
        check_eq("acc_wrap", result10, 10'd506);
        check_eq("acc_wrap_ovf", overflow10, 1'b1);
        check_eq("acc_wide", result16, 16'd1530);
        check_eq("acc_wide_ovf", overflow16, 1'b0);

        // Saturating accumulate
        beat(MODE_SAT, 8'd0, 8'd0, 1'b1);
        check_eq("sat_clr0", result10, 10'd0);
        beat(MODE_SAT, 8'd255, 8'd255, 1'b0);
        beat(MODE_SAT, 8'd255, 8'd255, 1'b0);
        check_eq("sat_2", result10, 10'd1020);
        beat(MODE_SAT, 8'd255, 8'd255, 1'b0);
        check_eq("sat_clamp", result10, 10'd1023);
        check_eq("sat_clamp_ovf", overflow10, 1'b1);
        beat(MODE_SAT, 8'd0, 8'd0, 1'b0);
        check_eq("sat_hold", result10, 10'd1023);
        check_eq("sat_hold_ovf", overflow10, 1'b0);

        // Clear behaviour
        beat(MODE_ACC, 8'd255, 8'd255, 1'b1);
        beat(MODE_ACC, 8'd255, 8'd255, 1'b0);
        check_eq("clr_pre", result10, 10'd1020);
        beat(MODE_ACC, 8'd3, 8'd4, 1'b1);
        check_eq("clr_acc", result10, 10'd7);
        beat(MODE_ACC, 8'd1, 8'd0, 1'b0);
        check_eq("clr_after", result10, 10'd8);
        clear = 1'b1;
        idle();
        clear = 1'b0;
        beat(MODE_ACC, 8'd0, 8'd0, 1'b0);
        check_eq("clr_no_beat", result10, 10'd8);
        beat(MODE_ADD, 8'd10, 8'd20, 1'b1);
        check_eq("clr_add_result", result10, 10'd30);
        beat(MODE_ACC, 8'd0, 8'd0, 1'b0);
        check_eq("clr_add_acc", result10, 10'd0);
        check_eq("count_mid", count16, 8'd21);

        // Counter wrap: 21 beats so far, 234 more gives 255, one more wraps
        in_valid = 1'b1; mode = MODE_ADD; a = 8'd1; b = 8'd2;
        repeat (234) @(posedge clk);
        #1;
        check_eq("count_255", count16, 8'd255);
        @(posedge clk);
        #1;
        check_eq("count_wrap", count16, 8'd0);
        check_eq("count_wrap10", count10, 8'd0);
        in_valid = 1'b0;

        // Asynchronous reset with a result pending
        out_ready = 1'b0;
        beat(MODE_ADD, 8'd1, 8'd2, 1'b0);
        check_eq("arst_pre_valid", out_valid16, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_valid", out_valid16, 1'b0);
        check_eq("arst_result", result16, 16'd0);
        check_eq("arst_count", count16, 8'd0);
        check_eq("arst_in_ready", in_ready16, 1'b0);
        idle();
        rst = 1'b0;
        out_ready = 1'b1;
        beat(MODE_ACC, 8'd4, 8'd5, 1'b0);
        check_eq("arst_acc_lost", result10, 10'd9);
        check_eq("arst_count_restart", count16, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
